// File: rtl/instr_encoder.sv
// Packs field-level requests into RV64 instruction words and queues them in a small FIFO
// presented to a consumer with valid/ready; illegal requests queue as a zero word plus a flag.
module instr_encoder #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       cls_i,
  input  logic [2:0]       funct3_i,
  input  logic             alt_i,
  input  logic             mext_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [4:0]       rd_i,
  input  logic [11:0]      imm_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      instruction_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = PtrW + 1;

  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcOpImm32 = 7'b0011011;
  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcBranch  = 7'b1100011;

  logic [6:0]  f7;
  logic [31:0] enc_word;
  logic        enc_illegal;

  always_comb begin
    f7          = mext_i ? 7'h01 : (alt_i ? 7'h20 : 7'h00);
    enc_word    = '0;
    enc_illegal = alt_i & mext_i;
    case (cls_i)
      3'd0: begin
        enc_word = {f7, rs2_i, rs1_i, funct3_i, rd_i, OpcOp};
        if (alt_i && !(funct3_i == 3'b000 || funct3_i == 3'b101)) enc_illegal = 1'b1;
      end
      3'd1: begin
        if (mext_i) enc_illegal = 1'b1;
        if (funct3_i == 3'b000) begin
          enc_word = {imm_i, rs1_i, 3'b000, rd_i, OpcOpImm32};
        end else if (funct3_i == 3'b001 || funct3_i == 3'b101) begin
          enc_word = {f7, imm_i[4:0], rs1_i, funct3_i, rd_i, OpcOpImm32};
        end else begin
          enc_illegal = 1'b1;
        end
        if (alt_i && funct3_i != 3'b101) enc_illegal = 1'b1;
      end
      3'd2: begin
        enc_word = {imm_i, rs1_i, funct3_i, rd_i, OpcLoad};
        if (funct3_i == 3'b111) enc_illegal = 1'b1;
      end
      3'd3: begin
        enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OpcStore};
        if (funct3_i > 3'b011) enc_illegal = 1'b1;
      end
      3'd4: begin
        // imm holds offset[12:1], so imm[11] is offset[12] and imm[10] is offset[11]
        enc_word = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i, imm_i[3:0], imm_i[10],
                    OpcBranch};
        if (funct3_i == 3'b010 || funct3_i == 3'b011) enc_illegal = 1'b1;
      end
      default: enc_illegal = 1'b1;
    endcase
    if (enc_illegal) enc_word = '0;
  end

  logic [32:0]      mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, empty, push, pop;
  logic [32:0]      head;

  assign full        = (occ_q == OccW'(DEPTH));
  assign empty       = (occ_q == '0);
  assign req_ready_o = ~full;
  assign out_valid_o = ~empty;
  assign push        = req_valid_i & req_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        cnt_d    = cnt_q + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + OccW'(1);
        2'b01:   occ_d = occ_q - OccW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only observable while occupancy is non-zero.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem_q[wr_ptr_q] <= {enc_illegal, enc_word};
  end

  assign instruction_o = empty ? 32'h0 : head[31:0];
  assign illegal_o     = empty ? 1'b0 : head[32];
  assign count_o       = cnt_q;

endmodule
